quad_mac_arbiter: RTL and testbench
===================================

# quad_mac_arbiter

Shares one two-stage Horner quadratic MAC (result = (a·x + b)·x + c) between two requesters. Each requester presents coefficient/operand sets on a valid/ready handshake. A round-robin arbiter issues at most one set per cycle into the pipe. Results are returned through a per-requester result FIFO, and a credit check guarantees no result is ever dropped.

## Interface
Parameters:
- DATA_W, 8: width of a, b, c, x.
- RES_W, 16: width of internal stage register and result.
- FIFO_DEPTH, 2: result FIFO entries per requester (power of two, ≥2).

Ports (index i ∈ {0,1}; flattened buses, requester i occupies slice i):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  requester i has a set pending.
- req_ready  out  2  set i accepted this cycle (one-hot or zero).
- req_a, req_b, req_c, req_x  in  2·DATA_W each  operands per requester.
- rsp_valid  out  2  FIFO i non-empty.
- rsp_ready  in  2  requester i pops its FIFO head.
- rsp_result  out  2·RES_W  FIFO i head.
- busy  out  1  any set in flight or any FIFO non-empty.

## Operation
- Eligibility: requester i is eligible when req_valid[i] and occ[i] + inflight[i] − pop[i] < FIFO_DEPTH, where pop[i] = rsp_valid[i] & rsp_ready[i] in the same cycle. Consequently req_ready depends combinationally on rsp_ready.
- Arbitration: round-robin over eligible requesters. The last granted requester gets the lowest priority. The pointer updates only on a grant. With no grant the pointer holds.
- Issue: on grant, stage 1 captures s1 = (a·x + b) mod 2^RES_W, along with x, c and a 1-bit tag. Stage 1 valid is cleared when there is no grant.
- Stage 2: computes (s1·x + c) mod 2^RES_W and pushes it into FIFO[tag]. Products and sums are unsigned and truncated to RES_W.
- FIFO: push and pop in the same cycle on a full FIFO is legal, and occupancy is unchanged. Pop on an empty FIFO is ignored. Push to a full FIFO cannot occur because of the credit rule; verification asserts this.
- Per-requester ordering is preserved. There is no ordering across requesters.

## Timing
- Set accepted in cycle n → result pushed at the end of cycle n+1 → rsp_valid high from cycle n+2. Latency is 2.
- Throughput: one set per cycle total. A single requester sustains 1/cycle when rsp_ready is held high and FIFO_DEPTH ≥ 2.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, busy=0. Stage valid bits are cleared, FIFOs are emptied, inflight counters are zeroed, and the RR pointer is set so requester 0 wins the first tie.
- Reset mid-operation: in-flight sets and buffered results are discarded without notice. Acceptance resumes on the first cycle after reset deasserts.
- Both requesters valid and eligible: exactly one is granted and the other waits. With a stable request pattern the grants alternate.

## Configuration
- QUAD_ARB_FIXED_PRIO_EN defined: fixed priority, where requester 0 always wins when eligible. The RR pointer is not built. Requester 1 may starve; this is intended for a latency-critical port 0.
- Not defined: round-robin as described above.

## Structure
- Package quad_arb_pkg holds DATA_W/RES_W defaults, N_REQ = 2, the tag type, and the FIFO pointer width function.
- Sub-module quad_mac_pipe is the two-stage Horner datapath with valid/tag sideband. Arbiter, credit counters and FIFOs remain in the top level.

## Test plan
- Single op: req0 a=2, x=3, b=4, c=5, rsp_ready=1 → rsp_result[0]=0x0023 in cycle n+2, valid one cycle.
- Overflow: a=b=c=x=255 → 0x01FF (stage 1 = 0xFF00, truncated multiply).
- Contention: both valid continuously, rsp_ready=11 → grants alternate 0,1,0,1 starting with 0 after reset. Each FIFO receives its own results in order.
- Backpressure: req0 streaming, rsp_ready[0]=0 → exactly FIFO_DEPTH sets accepted, then req_ready[0]=0. Raising rsp_ready resumes 1/cycle with no lost or duplicated result.
- Reset mid-flight: assert reset the cycle after a grant → no rsp_valid afterwards, busy=0 next cycle, and a fresh op completes normally.
- With QUAD_ARB_FIXED_PRIO_EN: both valid continuously → requester 1 is never granted while requester 0 is eligible.

Source files
------------

// File: rtl/quad_arb_pkg.sv
// Shared types and defaults for the quadratic MAC arbiter.
package quad_arb_pkg;

  localparam int unsigned DataWDef = 8;
  localparam int unsigned ResWDef  = 16;
  localparam int unsigned N_REQ    = 2;

  // Identifies which requester a result belongs to.
  typedef logic tag_t;

  // Width of a FIFO read/write pointer for a power-of-two depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/quad_mac_arbiter_if.sv
// Requester-side bus for quad_mac_arbiter: flattened per-requester handshakes.
interface quad_mac_arbiter_if
  import quad_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned RES_W  = ResWDef
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*DATA_W-1:0] req_c;
  logic [N_REQ*DATA_W-1:0] req_x;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [N_REQ*RES_W-1:0]  rsp_result;
  logic                    busy;

  // Requesters drive operands and pop results.
  modport master (
    output req_valid, req_a, req_b, req_c, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy
  );

  // The shared MAC accepts operands and returns results.
  modport slave (
    input  req_valid, req_a, req_b, req_c, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_result, busy
  );

endinterface

// File: rtl/quad_mac_pipe.sv
// Two-stage Horner datapath: stage 1 registers a*x+b, stage 2 is combinational s1*x+c.
module quad_mac_pipe
  import quad_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned RES_W  = ResWDef
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  input  tag_t              in_tag_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [DATA_W-1:0] x_i,
  output logic              out_valid_o,
  output tag_t              out_tag_o,
  output logic [RES_W-1:0]  out_result_o
);

  logic [RES_W-1:0] s1_d, s1_q;
  logic [RES_W-1:0] x_q, c_q;
  logic             vld_q;
  tag_t             tag_q;

  // Stage 1 product-sum, truncated to RES_W.
  always_comb begin
    s1_d = RES_W'(a_i) * RES_W'(x_i) + RES_W'(b_i);
  end

  // Stage 1 register; valid simply follows the issue strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= 1'b0;
      tag_q <= 1'b0;
      s1_q  <= '0;
      x_q   <= '0;
      c_q   <= '0;
    end else begin
      vld_q <= in_valid_i;
      if (in_valid_i) begin
        tag_q <= in_tag_i;
        s1_q  <= s1_d;
        x_q   <= RES_W'(x_i);
        c_q   <= RES_W'(c_i);
      end
    end
  end

  // Stage 2 result, pushed into the tagged FIFO at the end of this cycle.
  always_comb begin
    out_valid_o  = vld_q;
    out_tag_o    = tag_q;
    out_result_o = s1_q * x_q + c_q;
  end

endmodule

// File: rtl/quad_mac_arbiter.sv
// Shares one Horner quadratic MAC between two requesters with per-requester result FIFOs.
// Credit check (occupancy + in-flight - pop < depth) guarantees a FIFO never overflows.
// Define QUAD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module quad_mac_arbiter
  import quad_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDef,
  parameter int unsigned RES_W      = ResWDef,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  quad_mac_arbiter_if.slave bus
);

  localparam int unsigned PtrW = ptr_w(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [N_REQ-1:0] elig, grant, pop, push, rsp_vld;
  logic [CntW-1:0]  occ_q  [N_REQ];
  logic [CntW-1:0]  occ_d  [N_REQ];
  logic [1:0]       infl_q [N_REQ];
  logic [1:0]       infl_d [N_REQ];
  logic [PtrW-1:0]  wptr_q [N_REQ];
  logic [PtrW-1:0]  wptr_d [N_REQ];
  logic [PtrW-1:0]  rptr_q [N_REQ];
  logic [PtrW-1:0]  rptr_d [N_REQ];
  logic [RES_W-1:0] mem_q  [N_REQ][FIFO_DEPTH];
  logic [N_REQ*RES_W-1:0] rsp_res;

  tag_t              sel;
  logic [DATA_W-1:0] a_mux, b_mux, c_mux, x_mux;
  logic              pipe_vld;
  tag_t              pipe_tag;
  logic [RES_W-1:0]  pipe_res;

  // Pops and credit-based eligibility; a same-cycle pop frees a slot.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_vld[i] = (occ_q[i] != '0);
      pop[i]     = rsp_vld[i] && bus.rsp_ready[i] && !reset;
      elig[i]    = bus.req_valid[i] && !reset &&
                   ((32'(occ_q[i]) + 32'(infl_q[i])) < (FIFO_DEPTH + 32'(pop[i])));
    end
  end

`ifdef QUAD_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 always wins when eligible.
  always_comb begin
    grant = '0;
    if (elig[0])      grant = 2'b01;
    else if (elig[1]) grant = 2'b10;
  end
`else
  // rr_q holds the last granted requester; it drops to lowest priority.
  logic rr_d, rr_q;

  // Round-robin grant over eligible requesters.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = rr_q ? 2'b01 : 2'b10;
    rr_d = (grant != '0) ? grant[1] : rr_q;
  end

  // Pointer register; reset value lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b1;
    else       rr_q <= rr_d;
  end
`endif

  // Operand mux for the granted requester.
  always_comb begin
    sel   = grant[1];
    a_mux = sel ? bus.req_a[DATA_W +: DATA_W] : bus.req_a[0 +: DATA_W];
    b_mux = sel ? bus.req_b[DATA_W +: DATA_W] : bus.req_b[0 +: DATA_W];
    c_mux = sel ? bus.req_c[DATA_W +: DATA_W] : bus.req_c[0 +: DATA_W];
    x_mux = sel ? bus.req_x[DATA_W +: DATA_W] : bus.req_x[0 +: DATA_W];
  end

  quad_mac_pipe #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_pipe (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_valid_i   (grant != '0),
    .in_tag_i     (sel),
    .a_i          (a_mux),
    .b_i          (b_mux),
    .c_i          (c_mux),
    .x_i          (x_mux),
    .out_valid_o  (pipe_vld),
    .out_tag_o    (pipe_tag),
    .out_result_o (pipe_res)
  );

  // Next-state for FIFO pointers, occupancy and in-flight credit counters.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      push[i]   = pipe_vld && (pipe_tag == tag_t'(i));
      occ_d[i]  = occ_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      infl_d[i] = infl_q[i] + 2'(grant[i]) - 2'(push[i]);
      wptr_d[i] = wptr_q[i] + PtrW'(push[i]);
      rptr_d[i] = rptr_q[i] + PtrW'(pop[i]);
    end
  end

  // FIFO and credit state; reset discards buffered and in-flight results.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        occ_q[i]  <= '0;
        infl_q[i] <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end else begin
        occ_q[i]  <= occ_d[i];
        infl_q[i] <= infl_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        if (push[i]) mem_q[i][wptr_q[i]] <= pipe_res;
      end
    end
  end

  // Outputs; result is forced to zero while a FIFO is empty.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_res[i*RES_W +: RES_W] = rsp_vld[i] ? mem_q[i][rptr_q[i]] : '0;
    end
    bus.req_ready  = grant;
    bus.rsp_valid  = rsp_vld;
    bus.rsp_result = rsp_res;
    bus.busy       = pipe_vld || (rsp_vld != '0);
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_no_overflow
    assert property (@(posedge clk) disable iff (reset)
      !(push[g] && (occ_q[g] == CntW'(FIFO_DEPTH)) && !pop[g]));
  end

endmodule

// File: tb/tb_quad_mac_arbiter.sv
// Self-checking bench for quad_mac_arbiter with a per-requester result scoreboard.
module tb_quad_mac_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  quad_mac_arbiter_if #(.DATA_W(8), .RES_W(16)) bus ();

  quad_mac_arbiter #(
    .DATA_W     (8),
    .RES_W      (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic, truncated to 16 bits.
  function automatic logic [15:0] horner(input logic [7:0] a, b, c, x);
    int unsigned t;
    t = (32'(a) * 32'(x) + 32'(b)) % 65536;
    t = (t * 32'(x) + 32'(c)) % 65536;
    return t[15:0];
  endfunction

  // Scoreboard: push expectation on acceptance, pop and compare on each result pop.
  always @(negedge clk) begin
    if (reset) begin
      exp0.delete();
      exp1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] e, got;
        if (bus.req_ready[i]) begin
          e = horner(bus.req_a[i*8 +: 8], bus.req_b[i*8 +: 8],
                     bus.req_c[i*8 +: 8], bus.req_x[i*8 +: 8]);
          if (i == 0) exp0.push_back(e);
          else        exp1.push_back(e);
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          got = bus.rsp_result[i*16 +: 16];
          checks++;
          if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
            errors++;
            $display("FAIL scoreboard rsp%0d: got %h, required no result", i, got);
          end else begin
            e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL scoreboard rsp%0d: got %h, required %h", i, got, e);
            end
          end
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [7:0] a, b, c, x);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_c[i*8 +: 8] = c;
    bus.req_x[i*8 +: 8] = x;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s drain busy: got %b, required 0", name, bus.busy);
    end
    checks++;
    if (exp0.size() + exp1.size() != 0) begin
      errors++;
      $display("FAIL %s drain leftovers: got %0d pending, required 0", name,
               exp0.size() + exp1.size());
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    set_ops(0, 8'd1, 8'd1, 8'd1, 8'd1);
    set_ops(1, 8'd1, 8'd1, 8'd1, 8'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset req_ready: got %b, required 00", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL reset rsp_valid: got %b, required 00", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_result !== 32'h0) begin
      errors++; $display("FAIL reset rsp_result: got %h, required 0", bus.rsp_result);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset busy: got %b, required 0", bus.busy);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset         = 1'b0;
  endtask

  // One op on requester 0 with exact latency checks.
  task automatic run_single(input string name, input logic [7:0] a, b, c, x,
                            input logic [15:0] expv);
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    set_ops(0, a, b, c, x);
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL %s accept: got %b, required 01", name, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s n+1: got rsp_valid=%b busy=%b, required 00/1", name,
               bus.rsp_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_result[15:0] !== expv) begin
      errors++;
      $display("FAIL %s n+2: got valid=%b result=%h, required 01/%h", name,
               bus.rsp_valid, bus.rsp_result[15:0], expv);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL %s one-cycle valid: got %b, required 00", name, bus.rsp_valid);
    end
  endtask

  task automatic test_single_op();
    run_single("single_op", 8'd2, 8'd4, 8'd5, 8'd3, 16'h0023);
  endtask

  task automatic test_overflow();
    run_single("overflow", 8'd255, 8'd255, 8'd255, 8'd255, 16'h01FF);
  endtask

  task automatic test_contention();
    logic [1:0] expg;
    do_reset();
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      set_ops(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      set_ops(1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      bus.req_valid = 2'b11;
`ifdef QUAD_ARB_FIXED_PRIO_EN
      expg = 2'b01;
`else
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      @(negedge clk);
      checks++;
      if (bus.req_ready !== expg) begin
        errors++;
        $display("FAIL contention grant %0d: got %b, required %b", k, bus.req_ready, expg);
      end
    end
    @(posedge clk); #1;
    drain("contention");
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset();
    bus.rsp_ready = 2'b10;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      set_ops(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      bus.req_valid = 2'b01;
      @(negedge clk);
      if (bus.req_ready[0]) acc++;
    end
    checks++;
    if (acc != 2) begin
      errors++; $display("FAIL backpressure accepted: got %0d, required 2", acc);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL backpressure stall: got %b, required 00", bus.req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.rsp_ready = 2'b11;
      set_ops(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
        errors++;
        $display("FAIL backpressure resume %0d: got %b, required 01", k, bus.req_ready);
      end
    end
    @(posedge clk); #1;
    drain("backpressure");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL midflight grant: got %b, required 01", bus.req_ready);
    end
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    set_ops(0, 8'd2, 8'd4, 8'd5, 8'd3);
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL midflight flushed: got busy=%b rsp_valid=%b, required 0/00",
               bus.busy, bus.rsp_valid);
    end
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL midflight resume: got %b, required 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL midflight discarded: got %b, required 00", bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_result[15:0] !== 16'h0023) begin
      errors++;
      $display("FAIL midflight fresh op: got valid=%b result=%h, required 01/0023",
               bus.rsp_valid, bus.rsp_result[15:0]);
    end
    drain("midflight");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.req_x     = '0;
    test_reset();
    test_single_op();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
